// File: rtl/filter_line_sequencer.sv
// filter_line_sequencer
//   Drives the 3x3 line filter from a frame buffer. Source lines are fetched
//   one pixel at a time and pushed into the filter, with one flt_wren pulse
//   per pixel. Once three lines are resident, the cursor sweeps the interior
//   columns of the middle line. Each filtered pixel is then written to the
//   destination frame.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   start             begin a frame (ignored unless idle)
//   busy, done, err   status: running, end-of-frame pulse, sticky filter timeout
//   src_rd/src_addr   one-cycle source read request and its address
//   src_q/src_valid   source read data and its valid strobe
//   flt_d_in/flt_wren pixel written into the filter line store
//   flt_cursor        column the filter works on (zero-extended col)
//   flt_d_out/d_rdy   filtered pixel and its ready flag
//   dst_wr/addr/data  one-cycle destination write
module filter_line_sequencer #(
    parameter int unsigned LINE_LENGTH = 720,
    parameter int unsigned NUM_LINES   = 480,
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned MIN_HOLD    = 3,
    parameter int unsigned FLT_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              src_rd,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [15:0]       src_q,
    input  logic              src_valid,
    output logic [15:0]       flt_d_in,
    output logic              flt_wren,
    output logic [9:0]        flt_cursor,
    input  logic [15:0]       flt_d_out,
    input  logic              flt_d_rdy,
    output logic              dst_wr,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [15:0]       dst_data
);

    localparam int unsigned COL_W  = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
    localparam int unsigned ROW_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int unsigned HOLD_W = $clog2(MIN_HOLD + FLT_TIMEOUT + 1);

    localparam logic [COL_W-1:0]  COL_LAST       = COL_W'(LINE_LENGTH - 1);
    localparam logic [COL_W-1:0]  COL_SWEEP_LAST = COL_W'(LINE_LENGTH - 2);
    localparam logic [ROW_W-1:0]  ROW_LAST       = ROW_W'(NUM_LINES - 1);
    localparam logic [ADDR_W-1:0] LINE_A         = ADDR_W'(LINE_LENGTH);
    localparam logic [HOLD_W-1:0] HOLD_MIN       = HOLD_W'(MIN_HOLD);
    // Last hold count at which d_rdy may still arrive before the pixel is abandoned.
    localparam logic [HOLD_W-1:0] HOLD_LAST      = HOLD_W'(MIN_HOLD + FLT_TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrPulse,
        StWrGap,
        StSwSet,
        StSwHold,
        StDstWr,
        StRowEnd,
        StFin
    } state_e;

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [15:0]       pixel_q, pixel_d;
    logic [15:0]       result_q, result_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            row_q    <= '0;
            col_q    <= '0;
            base_q   <= '0;
            hold_q   <= '0;
            pixel_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            base_q   <= base_d;
            hold_q   <= hold_d;
            pixel_q  <= pixel_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        base_d   = base_q;
        hold_d   = hold_q;
        pixel_d  = pixel_q;
        result_d = result_q;
        err_d    = err_q;

        busy     = 1'b1;
        done     = 1'b0;
        src_rd   = 1'b0;
        src_addr = '0;
        flt_d_in = '0;
        flt_wren = 1'b0;
        dst_wr   = 1'b0;
        dst_addr = '0;
        dst_data = '0;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    row_d   = '0;
                    col_d   = '0;
                    base_d  = '0;
                    err_d   = 1'b0;
                    state_d = StRdReq;
                end
            end
            StRdReq: begin
                src_rd   = 1'b1;
                src_addr = base_q + ADDR_W'(col_q);
                state_d  = StRdWait;
            end
            StRdWait: begin
                if (src_valid) begin
                    pixel_d = src_q;
                    state_d = StWrPulse;
                end
            end
            StWrPulse: begin
                flt_wren = 1'b1;
                flt_d_in = pixel_q;
                state_d  = StWrGap;
            end
            StWrGap: begin
                // Dead cycle so consecutive pixels give distinct wren edges.
                if (col_q == COL_LAST) begin
                    state_d = StRowEnd;
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = StRdReq;
                end
            end
            StRowEnd: begin
                if (row_q >= ROW_W'(2)) begin
                    // Three lines resident: sweep the middle one (row-1).
                    col_d   = COL_W'(1);
                    state_d = StSwSet;
                end else begin
                    row_d   = row_q + 1'b1;
                    base_d  = base_q + LINE_A;
                    col_d   = '0;
                    state_d = StRdReq;
                end
            end
            StSwSet: begin
                hold_d  = '0;
                state_d = StSwHold;
            end
            StSwHold: begin
                // d_rdy is not trusted until the cursor has settled for MIN_HOLD cycles.
                if (hold_q >= HOLD_MIN && flt_d_rdy) begin
                    result_d = flt_d_out;
                    state_d  = StDstWr;
                end else if (hold_q == HOLD_LAST) begin
                    result_d = 16'h0000;
                    err_d    = 1'b1;
                    state_d  = StDstWr;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StDstWr: begin
                dst_wr   = 1'b1;
                dst_addr = base_q - LINE_A + ADDR_W'(col_q);
                dst_data = result_q;
                if (col_q == COL_SWEEP_LAST) begin
                    if (row_q == ROW_LAST) begin
                        state_d = StFin;
                    end else begin
                        row_d   = row_q + 1'b1;
                        base_d  = base_q + LINE_A;
                        col_d   = '0;
                        state_d = StRdReq;
                    end
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = StSwSet;
                end
            end
            StFin: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign err        = err_q;
    assign flt_cursor = 10'(col_q);

endmodule

// File: tb/tb_filter_line_sequencer.sv
// Directed bench for filter_line_sequencer with an 8x4 frame. A source
// memory model returns src[a]=a, and a filter model raises d_rdy once the
// cursor has been stable for 3 cycles, with flt_d_out = 16'h5A00 ^ cursor.
module tb_filter_line_sequencer;

    localparam int unsigned LL = 8;
    localparam int unsigned NL = 4;
    localparam int unsigned AW = 20;
    localparam int          LIMIT = 3000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, err, src_rd, flt_wren, dst_wr;
    logic [AW-1:0] src_addr, dst_addr;
    logic [15:0]   src_q = '0;
    logic          src_valid = 1'b0;
    logic [15:0]   flt_d_in, dst_data;
    logic [9:0]    flt_cursor;
    logic [15:0]   flt_d_out = '0;
    logic          flt_d_rdy = 1'b0;

    filter_line_sequencer #(
        .LINE_LENGTH(LL),
        .NUM_LINES  (NL),
        .ADDR_W     (AW),
        .MIN_HOLD   (3),
        .FLT_TIMEOUT(15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .src_rd    (src_rd),
        .src_addr  (src_addr),
        .src_q     (src_q),
        .src_valid (src_valid),
        .flt_d_in  (flt_d_in),
        .flt_wren  (flt_wren),
        .flt_cursor(flt_cursor),
        .flt_d_out (flt_d_out),
        .flt_d_rdy (flt_d_rdy),
        .dst_wr    (dst_wr),
        .dst_addr  (dst_addr),
        .dst_data  (dst_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus knobs.
    int mode = 0;          // 0: d_rdy after 3 stable cycles, 1: always high, 2: stuck at col 3
    int slow_addr = -1;
    int slow_delay = 6;

    // Logs filled by the monitor.
    int          cyc = 0;
    logic [9:0]  wren_cur[$];
    logic [15:0] wren_din[$];
    logic [AW-1:0] dst_a[$];
    logic [15:0] dst_d[$];
    int          dst_cyc[$];
    logic [AW-1:0] rd_a[$];
    int          done_n = 0;
    int          both_hi = 0;
    int          rd_overlap = 0;

    // Source memory: responds src_delay cycles after src_rd.
    logic          pend = 1'b0;
    int            pcnt = 0;
    logic [15:0]   paddr = '0;
    always @(negedge clk) begin
        src_valid = 1'b0;
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                pcnt = pcnt - 1;
                if (pcnt == 0) begin
                    src_valid = 1'b1;
                    src_q     = paddr;
                    pend      = 1'b0;
                end
            end
            if (src_rd) begin
                if (pend) rd_overlap++;
                pend  = 1'b1;
                paddr = src_addr[15:0];
                pcnt  = (int'(src_addr) == slow_addr) ? slow_delay : 1;
            end
        end
    end

    // Filter model.
    logic [9:0] prev_cur = '0;
    int         stable = 0;
    always @(negedge clk) begin
        if (flt_cursor == prev_cur) stable++;
        else stable = 0;
        prev_cur  = flt_cursor;
        flt_d_out = 16'h5A00 ^ {6'b0, flt_cursor};
        case (mode)
            1:       flt_d_rdy = 1'b1;
            2:       flt_d_rdy = (stable >= 3) && !(flt_cursor == 10'd3 && dst_a.size() < 6);
            default: flt_d_rdy = (stable >= 3);
        endcase
    end

    // Monitor.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (flt_wren) begin
                wren_cur.push_back(flt_cursor);
                wren_din.push_back(flt_d_in);
            end
            if (dst_wr) begin
                dst_a.push_back(dst_addr);
                dst_d.push_back(dst_data);
                dst_cyc.push_back(cyc);
            end
            if (src_rd) rd_a.push_back(src_addr);
            if (done) done_n++;
            if (flt_wren && dst_wr) both_hi++;
        end
    end

    function automatic logic [AW-1:0] exp_addr(int i);
        return (i < 6) ? AW'(9 + i) : AW'(17 + i - 6);
    endfunction

    task automatic clear_logs();
        wren_cur.delete();
        wren_din.delete();
        dst_a.delete();
        dst_d.delete();
        dst_cyc.delete();
        rd_a.delete();
        done_n     = 0;
        both_hi    = 0;
        rd_overlap = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= LIMIT) begin
            errors++;
            $display("FAIL wait_done: done not seen within %0d cycles (actual busy=%b, required done=1)",
                     LIMIT, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, src_rd, flt_wren, dst_wr} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes: actual %b required 000000",
                     {busy, done, err, src_rd, flt_wren, dst_wr});
        end
        checks++;
        if (src_addr !== '0 || dst_addr !== '0) begin
            errors++;
            $display("FAIL reset_addr: actual src %0h dst %0h required 0 0", src_addr, dst_addr);
        end
        checks++;
        if (flt_cursor !== '0 || flt_d_in !== '0 || dst_data !== '0) begin
            errors++;
            $display("FAIL reset_data: actual cur %0h din %0h dd %0h required 0", flt_cursor,
                     flt_d_in, dst_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame();
        clear_logs();
        mode = 0;
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_busy: actual %b required 1", busy);
        end
        wait_done();
        checks++;
        if (wren_cur.size() != 32) begin
            errors++;
            $display("FAIL frame_wren_count: actual %0d required 32", wren_cur.size());
        end
        for (int i = 0; i < wren_cur.size(); i++) begin
            checks++;
            if (wren_cur[i] !== 10'(i % LL) || wren_din[i] !== 16'(i)) begin
                errors++;
                $display("FAIL frame_wren[%0d]: actual cur %0d din %0d required cur %0d din %0d",
                         i, wren_cur[i], wren_din[i], i % LL, i);
            end
        end
        checks++;
        if (dst_a.size() != 12) begin
            errors++;
            $display("FAIL frame_dst_count: actual %0d required 12", dst_a.size());
        end
        for (int i = 0; i < dst_a.size(); i++) begin
            checks++;
            if (dst_a[i] !== exp_addr(i) ||
                dst_d[i] !== (16'h5A00 ^ 16'(exp_addr(i) % LL))) begin
                errors++;
                $display("FAIL frame_dst[%0d]: actual %0d/%h required %0d/%h", i, dst_a[i],
                         dst_d[i], exp_addr(i), 16'h5A00 ^ 16'(exp_addr(i) % LL));
            end
        end
        checks++;
        if (done_n != 1 || both_hi != 0 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_status: actual done_n %0d overlap %0d err %b busy %b required 1 0 0 0",
                     done_n, both_hi, err, busy);
        end
    endtask

    task automatic test_src_delay();
        clear_logs();
        slow_addr = 5;
        pulse_start();
        wait_done();
        slow_addr = -1;
        checks++;
        if (rd_overlap != 0 || rd_a.size() != 32) begin
            errors++;
            $display("FAIL delay_src_rd: actual overlap %0d reads %0d required 0 32", rd_overlap,
                     rd_a.size());
        end
        checks++;
        if (wren_din.size() != 32) begin
            errors++;
            $display("FAIL delay_wren_count: actual %0d required 32", wren_din.size());
        end else begin
            checks++;
            if (wren_din[5] !== 16'd5 || wren_din[6] !== 16'd6) begin
                errors++;
                $display("FAIL delay_pixel5: actual %0d,%0d required 5,6", wren_din[5], wren_din[6]);
            end
        end
    endtask

    task automatic test_rdy_high();
        clear_logs();
        mode = 1;
        pulse_start();
        wait_done();
        mode = 0;
        checks++;
        if (dst_a.size() != 12) begin
            errors++;
            $display("FAIL high_dst_count: actual %0d required 12", dst_a.size());
        end
        // DST_WR + SW_SET + MIN_HOLD ignored cycles + one sampling cycle.
        for (int i = 1; i < dst_cyc.size(); i++) begin
            if (i != 6) begin
                checks++;
                if (dst_cyc[i] - dst_cyc[i-1] != 6) begin
                    errors++;
                    $display("FAIL high_spacing[%0d]: actual %0d required 6", i,
                             dst_cyc[i] - dst_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        mode = 2;
        pulse_start();
        wait_done();
        mode = 0;
        checks++;
        if (dst_a.size() != 12 || done_n != 1) begin
            errors++;
            $display("FAIL timeout_frame: actual writes %0d done %0d required 12 1", dst_a.size(),
                     done_n);
        end else begin
            checks++;
            if (dst_a[2] !== AW'(11) || dst_d[2] !== 16'h0000) begin
                errors++;
                $display("FAIL timeout_pixel: actual %0d/%h required 11/0000", dst_a[2], dst_d[2]);
            end
            // DST_WR + SW_SET + 3 ignored + 15 timeout cycles.
            checks++;
            if (dst_cyc[2] - dst_cyc[1] != 20 || dst_cyc[3] - dst_cyc[2] != 6) begin
                errors++;
                $display("FAIL timeout_spacing: actual %0d,%0d required 20,6",
                         dst_cyc[2] - dst_cyc[1], dst_cyc[3] - dst_cyc[2]);
            end
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err_set: actual %b required 1", err);
        end
        clear_logs();
        pulse_start();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_clear: actual %b required 0", err);
        end
        wait_done();
    endtask

    task automatic test_start_ignored();
        clear_logs();
        pulse_start();
        repeat (40) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        checks++;
        if (done_n != 1 || wren_din.size() != 32 || dst_a.size() != 12) begin
            errors++;
            $display("FAIL midstart: actual done %0d wrens %0d writes %0d required 1 32 12", done_n,
                     wren_din.size(), dst_a.size());
        end
        for (int i = 0; i < dst_a.size(); i++) begin
            checks++;
            if (dst_a[i] !== exp_addr(i)) begin
                errors++;
                $display("FAIL midstart_addr[%0d]: actual %0d required %0d", i, dst_a[i],
                         exp_addr(i));
            end
        end
        // Start during FIN must be ignored; held one more cycle, it is accepted.
        clear_logs();
        pulse_start();
        while (done !== 1'b1 && cyc < 90000) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL fin_start: actual busy %b done %b required 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL next_start: actual busy %b required 1", busy);
        end
        wait_done();
    endtask

    task automatic test_reset_mid_sweep();
        int n = 0;
        clear_logs();
        pulse_start();
        while (dst_a.size() < 2 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= LIMIT) begin
            errors++;
            $display("FAIL sweep_reach: actual writes %0d required 2", dst_a.size());
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, src_rd, flt_wren, dst_wr} !== 6'b0 || flt_cursor !== '0 ||
            src_addr !== '0 || dst_addr !== '0) begin
            errors++;
            $display("FAIL async_reset: actual %b cur %0d required 000000 0",
                     {busy, done, err, src_rd, flt_wren, dst_wr}, flt_cursor);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_logs();
        pulse_start();
        wait_done();
        checks++;
        if (rd_a.size() == 0 || rd_a[0] !== '0 || wren_din.size() == 0 || wren_din[0] !== 16'd0) begin
            errors++;
            $display("FAIL rerun_origin: actual reads %0d wrens %0d required first addr 0",
                     rd_a.size(), wren_din.size());
        end
        checks++;
        if (dst_a.size() != 12 || done_n != 1) begin
            errors++;
            $display("FAIL rerun_frame: actual writes %0d done %0d required 12 1", dst_a.size(),
                     done_n);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_src_delay();
        test_rdy_high();
        test_timeout();
        test_start_ignored();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
